// File: rtl/ram_writeback_mux.sv
// ram_writeback_mux
//   Write-back source select for the single-cycle CPU datapath. It passes either
//   the ALU result or a formatted load (byte/half extract with sign/zero extend)
//   from the RAM read port to the register file. Misaligned or illegal loads are
//   flagged combinationally, and the first one is latched into a sticky record.
//
// Ports
//   clk           in   rising-edge clock (sticky record only)
//   reset         in   synchronous, active-high; clears the sticky record
//   readData      in   32-bit aligned memory word, little-endian
//   ALUResult     in   ALU result / effective byte address
//   memToReg      in   1: formatted load data, 0: ALUResult
//   funct3        in   load type (lb/lh/lw/lbu/lhu)
//   clearFault    in   synchronous clear of the sticky record
//   writeDataReg  out  register-file write data (combinational)
//   loadFault     out  current-cycle fault (combinational)
//   faultSticky   out  set on first fault, held until reset/clearFault
//   faultAddr     out  ALUResult of the first fault since the last clear
module ram_writeback_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int FAULT_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] readData,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  memToReg,
  input  logic [2:0]            funct3,
  input  logic                  clearFault,
  output logic [DATA_WIDTH-1:0] writeDataReg,
  output logic                  loadFault,
  output logic                  faultSticky,
  output logic [DATA_WIDTH-1:0] faultAddr
);

  generate
    if (DATA_WIDTH != 32) begin : gBadWidth
      $error("ram_writeback_mux supports DATA_WIDTH = 32 only");
    end
  endgenerate

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } loadType_e;

  loadType_e   loadType;
  logic [1:0]  byteOff;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] fmtData;
  logic        fmtFault;

  assign loadType = loadType_e'(funct3);
  assign byteOff  = ALUResult[1:0];

  always_comb begin
    byteSel = readData[7:0];
    case (byteOff)
      2'd0:    byteSel = readData[7:0];
      2'd1:    byteSel = readData[15:8];
      2'd2:    byteSel = readData[23:16];
      2'd3:    byteSel = readData[31:24];
      default: byteSel = readData[7:0];
    endcase
  end

  assign halfSel = byteOff[1] ? readData[31:16] : readData[15:0];

  always_comb begin
    fmtData  = readData;
    fmtFault = 1'b0;
    case (loadType)
      LD_B:  fmtData = {{24{byteSel[7]}}, byteSel};
      LD_BU: fmtData = {24'h0, byteSel};
      LD_H: begin
        if (byteOff[0]) fmtFault = 1'b1;
        else            fmtData  = {{16{halfSel[15]}}, halfSel};
      end
      LD_HU: begin
        if (byteOff[0]) fmtFault = 1'b1;
        else            fmtData  = {16'h0, halfSel};
      end
      LD_W: begin
        if (byteOff != 2'b00) fmtFault = 1'b1;
      end
      default: fmtFault = 1'b1;
    endcase
  end

  always_comb begin
    writeDataReg = ALUResult;
    loadFault    = 1'b0;
    if (memToReg) begin
      loadFault = fmtFault;
      if (!fmtFault)            writeDataReg = fmtData;
      else if (FAULT_ZERO != 0) writeDataReg = '0;
      else                      writeDataReg = readData;
    end
  end

  // Clear takes priority over a same-cycle fault; only the first fault is recorded.
  always_ff @(posedge clk) begin
    if (reset || clearFault) begin
      faultSticky <= 1'b0;
      faultAddr   <= '0;
    end else if (loadFault && !faultSticky) begin
      faultSticky <= 1'b1;
      faultAddr   <= ALUResult;
    end
  end

endmodule

// File: tb/tb_ram_writeback_mux.sv
module tb_ram_writeback_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] readData;
  logic [31:0] ALUResult;
  logic        memToReg;
  logic [2:0]  funct3;
  logic        clearFault;
  logic [31:0] writeDataReg;
  logic        loadFault;
  logic        faultSticky;
  logic [31:0] faultAddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_writeback_mux #(.DATA_WIDTH(32), .FAULT_ZERO(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .readData     (readData),
    .ALUResult    (ALUResult),
    .memToReg     (memToReg),
    .funct3       (funct3),
    .clearFault   (clearFault),
    .writeDataReg (writeDataReg),
    .loadFault    (loadFault),
    .faultSticky  (faultSticky),
    .faultAddr    (faultAddr)
  );

  typedef struct {
    logic        m;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] expD;
    logic        expF;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: load result from shift/mask arithmetic on the byte address.
  function automatic void model(input logic m, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] rd, output logic [31:0] d, output logic flt);
    int unsigned a;
    logic [31:0] b;
    logic [31:0] h;
    a   = alu % 4;
    b   = (rd >> (8 * a)) & 32'hFF;
    h   = (rd >> (8 * a)) & 32'hFFFF;
    flt = 1'b0;
    d   = alu;
    if (m) begin
      if (f3 == 3'd0)      d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      else if (f3 == 3'd4) d = b;
      else if (f3 == 3'd1 || f3 == 3'd5) begin
        if (a % 2 == 1) flt = 1'b1;
        else if (f3 == 3'd1) d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        else d = h;
      end else if (f3 == 3'd2) begin
        if (a != 0) flt = 1'b1;
        else d = rd;
      end else flt = 1'b1;
      if (flt) d = 32'h0;
    end
  endfunction

  task automatic drive(input logic m, input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rd);
    memToReg = m; funct3 = f3; ALUResult = alu; readData = rd;
  endtask

  logic        mSticky;
  logic [31:0] mAddr;
  logic [31:0] eD;
  logic        eF;

  initial begin
    reset = 1'b1; clearFault = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sticky", {31'b0, faultSticky}, 32'h0);
    chk("reset_addr", faultAddr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    vecs.push_back('{1'b0, 3'd7, 32'h0000_0040, 32'h1234_5678, 32'h0000_0040, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0100, 32'h80FF_7F01, 32'h0000_0001, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0101, 32'h80FF_7F01, 32'h0000_007F, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0102, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{1'b1, 3'd4, 32'h0000_0103, 32'h80FF_7F01, 32'h0000_0080, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0103, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0});
    vecs.push_back('{1'b1, 3'd4, 32'h0000_0102, 32'h80FF_7F01, 32'h0000_00FF, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0200, 32'h8001_F00D, 32'hFFFF_F00D, 1'b0});
    vecs.push_back('{1'b1, 3'd5, 32'h0000_0202, 32'h8001_F00D, 32'h0000_8001, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0202, 32'h8001_F00D, 32'hFFFF_8001, 1'b0});
    vecs.push_back('{1'b1, 3'd5, 32'h0000_0200, 32'h8001_F00D, 32'h0000_F00D, 1'b0});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0021, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd5, 32'h0000_0023, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd3, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd6, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd7, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd3, 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b0});

    // Table vectors, with clearFault held so the sticky record stays empty.
    clearFault = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].m, vecs[i].f3, vecs[i].alu, vecs[i].rd);
      #1;
      chk($sformatf("vec%0d_data", i), writeDataReg, vecs[i].expD);
      chk($sformatf("vec%0d_fault", i), {31'b0, loadFault}, {31'b0, vecs[i].expF});
    end
    @(negedge clk);
    clearFault = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("table_sticky_clear", {31'b0, faultSticky}, 32'h0);

    // First fault captured, second fault ignored.
    @(negedge clk);
    drive(1'b1, 3'd2, 32'h0000_0012, 32'hDEAD_BEEF);
    #1;
    chk("lw_mis_data", writeDataReg, 32'h0);
    chk("lw_mis_fault", {31'b0, loadFault}, 32'h1);
    @(posedge clk); #1;
    chk("first_sticky", {31'b0, faultSticky}, 32'h1);
    chk("first_addr", faultAddr, 32'h0000_0012);
    @(negedge clk);
    drive(1'b1, 3'd1, 32'h0000_0021, 32'hDEAD_BEEF);
    #1;
    chk("lh_mis_fault", {31'b0, loadFault}, 32'h1);
    @(posedge clk); #1;
    chk("second_sticky", {31'b0, faultSticky}, 32'h1);
    chk("second_addr_hold", faultAddr, 32'h0000_0012);

    // Clear during an active fault wins.
    @(negedge clk);
    clearFault = 1'b1;
    @(posedge clk); #1;
    chk("clear_sticky", {31'b0, faultSticky}, 32'h0);
    chk("clear_addr", faultAddr, 32'h0);
    @(negedge clk);
    clearFault = 1'b0;
    @(posedge clk); #1;
    chk("refault_sticky", {31'b0, faultSticky}, 32'h1);
    chk("refault_addr", faultAddr, 32'h0000_0021);

    // Reset clears the record while the write-back path keeps tracking inputs.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 3'd0, 32'h0000_0001, 32'h80FF_7F01);
    #1;
    chk("reset_wb_data", writeDataReg, 32'h0000_007F);
    @(posedge clk); #1;
    chk("midreset_sticky", {31'b0, faultSticky}, 32'h0);
    chk("midreset_addr", faultAddr, 32'h0);
    chk("midreset_wb_data", writeDataReg, 32'h0000_007F);
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the reference model.
    mSticky = 1'b0;
    mAddr   = 32'h0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 29) == 0);
      clearFault = ($urandom_range(0, 14) == 0);
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom);
      #1;
      model(memToReg, funct3, ALUResult, readData, eD, eF);
      chk("rand_data", writeDataReg, eD);
      chk("rand_fault", {31'b0, loadFault}, {31'b0, eF});
      if (reset || clearFault) begin
        mSticky = 1'b0; mAddr = 32'h0;
      end else if (eF && !mSticky) begin
        mSticky = 1'b1; mAddr = ALUResult;
      end
      @(posedge clk); #1;
      chk("rand_sticky", {31'b0, faultSticky}, {31'b0, mSticky});
      chk("rand_addr", faultAddr, mAddr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
